// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - shared types and defaults for the T flip-flop count sequencer
package tff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } tff_ctrl_state_t;

    localparam int TFF_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with synchronous clear
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic t,
    output logic q,
    output logic qbar
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/tff_count_ctrl.sv
// rtl/tff_count_ctrl.sv - run/pause/done sequencer driving a bank of toggle cells as an up-counter
module tff_count_ctrl
    import tff_pkg::*;
#(
    parameter int WIDTH = TFF_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    tff_ctrl_state_t  state_q;
    tff_ctrl_state_t  state_d;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] inc_t;
    logic [WIDTH-1:0] qbar_unused;
    logic             clr;
    logic             load_limit;
    logic             carry;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_limit) begin
                limit_q <= limit;
            end
        end
    end

    // Ripple-carry toggle enables: a cell toggles when every lower cell is 1
    always_comb begin
        inc_t = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            inc_t[i] = carry;
            carry    = carry & count[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        t          = '0;
        clr        = 1'b0;
        load_limit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d    = ST_RUN;
                    load_limit = 1'b1;
                    clr        = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_PAUSE;
                end else if (count == limit_q) begin
                    state_d = ST_DONE;
                end else begin
                    t = inc_t;
                end
            end
            ST_PAUSE: begin
                // Resume edge only changes state; counting restarts next cycle
                if (start && !stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done = (state_q == ST_DONE);

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .t     (t[g]),
            .q     (count[g]),
            .qbar  (qbar_unused[g])
        );
    end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb/tb_tff_count_ctrl.sv - scoreboard bench for the T flip-flop count sequencer
module tb_tff_count_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] count;
        logic         busy;
        logic         done;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic         stop;
    logic [W-1:0] limit;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    exp_t sb[$];
    int   vectors;
    int   errors;

    // Reference model state: 0 idle, 1 run, 2 pause, 3 done
    int m_st;
    int m_cnt;
    int m_lim;

    tff_count_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .limit (limit),
        .count (count),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_push(input logic r, input logic s, input logic p, input logic [W-1:0] l);
        exp_t e;
        if (r) begin
            m_st = 0; m_cnt = 0; m_lim = 0;
        end else begin
            case (m_st)
                0: if (s && !p) begin m_st = 1; m_lim = int'(l); m_cnt = 0; end
                1: begin
                    if (p) m_st = 2;
                    else if (m_cnt == m_lim) m_st = 3;
                    else m_cnt = m_cnt + 1;
                end
                2: if (s && !p) m_st = 1;
                default: m_st = 0;
            endcase
        end
        e.count = m_cnt[W-1:0];
        e.busy  = (m_st == 1) || (m_st == 2);
        e.done  = (m_st == 3);
        sb.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic s, input logic p, input logic [W-1:0] l);
        reset = r; start = s; stop = p; limit = l;
        model_push(r, s, p, l);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
            e = sb.pop_front();
            vectors++;
            if ({count, busy, done} !== {e.count, e.busy, e.done}) begin
                errors++;
                $display("FAIL reset[%0d]: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, busy, done, e.count, e.busy, e.done);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, '0);
        e = sb.pop_front();
        vectors++;
        if ({count, busy, done} !== 6'b0000_00) begin
            errors++;
            $display("FAIL reset_release: got count=%0d busy=%b done=%b, want 0 0 0", count, busy, done);
        end
    endtask

    task automatic test_count;
        exp_t e;
        int busy_cycles = 0;
        int done_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, i == 0, 1'b0, 4'd5);
            e = sb.pop_front();
            vectors++;
            if ({count, busy, done} !== {e.count, e.busy, e.done}) begin
                errors++;
                $display("FAIL count[%0d]: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, busy, done, e.count, e.busy, e.done);
            end
            if (i <= 5 && count !== 4'(i)) begin
                errors++;
                $display("FAIL count_seq[%0d]: got %0d want %0d", i, count, i);
            end
            busy_cycles += int'(busy);
            done_cycles += int'(done);
        end
        vectors++;
        if (busy_cycles != 6 || done_cycles != 1 || count !== 4'd5) begin
            errors++;
            $display("FAIL count_totals: got busy=%0d done=%0d count=%0d, want 6 1 5",
                     busy_cycles, done_cycles, count);
        end
    endtask

    task automatic test_pause;
        exp_t e;
        int done_cycles = 0;
        // start, one counting edge, three stopped cycles, resume, then idle
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, (i == 0) || (i == 5), (i >= 2) && (i <= 4), 4'd3);
            e = sb.pop_front();
            vectors++;
            if ({count, busy, done} !== {e.count, e.busy, e.done}) begin
                errors++;
                $display("FAIL pause[%0d]: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, busy, done, e.count, e.busy, e.done);
            end
            if (i >= 2 && i <= 5 && (count !== 4'd1 || busy !== 1'b1)) begin
                errors++;
                $display("FAIL pause_hold[%0d]: got count=%0d busy=%b, want 1 1", i, count, busy);
            end
            done_cycles += int'(done);
        end
        vectors++;
        if (done_cycles != 1 || count !== 4'd3) begin
            errors++;
            $display("FAIL pause_done: got done=%0d count=%0d, want 1 3", done_cycles, count);
        end
    endtask

    task automatic test_limits;
        exp_t e;
        logic [W-1:0] lim;
        for (int k = 0; k < 2; k++) begin
            lim = (k == 0) ? 4'd0 : 4'd15;
            for (int i = 0; i < 22; i++) begin
                cycle(1'b0, i == 0, 1'b0, lim);
                e = sb.pop_front();
                vectors++;
                if ({count, busy, done} !== {e.count, e.busy, e.done}) begin
                    errors++;
                    $display("FAIL limit%0d[%0d]: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                             lim, i, count, busy, done, e.count, e.busy, e.done);
                end
            end
            vectors++;
            if (count !== lim || busy !== 1'b0) begin
                errors++;
                $display("FAIL limit%0d_end: got count=%0d busy=%b, want %0d 0", lim, count, busy, lim);
            end
        end
    endtask

    task automatic test_collide;
        exp_t e;
        // start with stop in idle: no run
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 4'd7);
            e = sb.pop_front();
            vectors++;
            if ({count, busy, done} !== {e.count, e.busy, e.done} || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_startstop[%0d]: got count=%0d busy=%b done=%b, want count=%0d busy=0 done=%b",
                         i, count, busy, done, e.count, e.done);
            end
        end
        // start held through DONE; limit changes mid-run and is re-sampled
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 1'b1, 1'b0, (i == 0) ? 4'd2 : 4'd4);
            e = sb.pop_front();
            vectors++;
            if ({count, busy, done} !== {e.count, e.busy, e.done}) begin
                errors++;
                $display("FAIL start_held[%0d]: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, busy, done, e.count, e.busy, e.done);
            end
        end
        // stop on the terminal edge pauses; resume completes
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, (i == 0) || (i == 4), i == 2, 4'd1);
            e = sb.pop_front();
            vectors++;
            if ({count, busy, done} !== {e.count, e.busy, e.done}) begin
                errors++;
                $display("FAIL stop_at_limit[%0d]: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, busy, done, e.count, e.busy, e.done);
            end
        end
    endtask

    task automatic test_reset_midrun;
        exp_t e;
        int done_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(i == 4, i == 0, 1'b0, 4'd10);
            e = sb.pop_front();
            vectors++;
            if ({count, busy, done} !== {e.count, e.busy, e.done}) begin
                errors++;
                $display("FAIL reset_midrun[%0d]: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                         i, count, busy, done, e.count, e.busy, e.done);
            end
            if (i == 3 && count !== 4'd3) begin
                errors++;
                $display("FAIL reset_midrun_pre: got count=%0d want 3", count);
            end
            if (i == 4 && (count !== 4'd0 || busy !== 1'b0)) begin
                errors++;
                $display("FAIL reset_midrun_post: got count=%0d busy=%b want 0 0", count, busy);
            end
            done_cycles += int'(done);
        end
        vectors++;
        if (done_cycles != 0) begin
            errors++;
            $display("FAIL reset_midrun_done: got %0d done cycles want 0", done_cycles);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        m_st = 0; m_cnt = 0; m_lim = 0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; limit = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_count();
        test_pause();
        test_limits();
        test_collide();
        test_reset_midrun();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
